// File: rtl/rast_pkg.sv
// Shared widths, traversal state encoding and delta sign-extension for the
// span traversal stage.
package rast_pkg;

    localparam int RAST_CW = 12;
    localparam int RAST_WW = 25;
    localparam int RAST_DW = 17;
    localparam int RAST_AW = 24;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SCAN,
        FLUSH
    } genpix_span_state_t;

    function automatic logic [RAST_WW-1:0] sext_dw(input logic [RAST_DW-1:0] d);
        return {{(RAST_WW-RAST_DW){d[RAST_DW-1]}}, d};
    endfunction

endpackage

// File: rtl/genpix_lane.sv
// One lane of a span beat: three edge weights at base+offset and the
// coverage decision including the right-hand bbox limit.
module genpix_lane #(
    parameter int CW = 12,
    parameter int WW = 25,
    parameter int K  = 0
) (
    input  logic [WW-1:0] i_base0,
    input  logic [WW-1:0] i_base1,
    input  logic [WW-1:0] i_base2,
    input  logic [WW-1:0] i_off0,
    input  logic [WW-1:0] i_off1,
    input  logic [WW-1:0] i_off2,
    input  logic [CW-1:0] i_x_c,
    input  logic [CW-1:0] i_x_max,
    output logic [WW-1:0] o_w0,
    output logic [WW-1:0] o_w1,
    output logic [WW-1:0] o_w2,
    output logic          o_inside
);

    logic [CW:0] w_x_lane;

    assign o_w0 = i_base0 + i_off0;
    assign o_w1 = i_base1 + i_off1;
    assign o_w2 = i_base2 + i_off2;

    // One extra bit so lanes past x = 2^CW-1 are rejected instead of wrapping.
    assign w_x_lane = {1'b0, i_x_c} + (CW+1)'(K);

    assign o_inside = ~o_w0[WW-1] & ~o_w1[WW-1] & ~o_w2[WW-1]
                    & (w_x_lane <= {1'b0, i_x_max});

endmodule

// File: rtl/genpix_span.sv
// Bounding-box traversal emitting LANES adjacent pixels per beat with edge
// weights and coverage mask; optionally drops fully uncovered beats.
module genpix_span
    import rast_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int CW         = RAST_CW,
    parameter int WW         = RAST_WW,
    parameter int DW         = RAST_DW,
    parameter int AW         = RAST_AW,
    parameter int CULL_EMPTY = 1
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [AW-1:0]       area_i,
    input  logic [DW-1:0]       dl_w0_col_i,
    input  logic [DW-1:0]       dl_w1_col_i,
    input  logic [DW-1:0]       dl_w2_col_i,
    input  logic [DW-1:0]       dl_w0_row_i,
    input  logic [DW-1:0]       dl_w1_row_i,
    input  logic [DW-1:0]       dl_w2_row_i,
    input  logic [WW-1:0]       w0_row_i,
    input  logic [WW-1:0]       w1_row_i,
    input  logic [WW-1:0]       w2_row_i,
    input  logic [CW-1:0]       x_min_i,
    input  logic [CW-1:0]       y_min_i,
    input  logic [CW-1:0]       x_max_i,
    input  logic [CW-1:0]       y_max_i,
    input  logic                valid_i,
    output logic                busy_o,
    output logic [CW-1:0]       x_o,
    output logic [CW-1:0]       y_o,
    output logic [LANES*WW-1:0] w0_o,
    output logic [LANES*WW-1:0] w1_o,
    output logic [LANES*WW-1:0] w2_o,
    output logic [LANES-1:0]    mask_o,
    output logic [AW-1:0]       area_o,
    output logic                valid_o,
    input  logic                busy_i,
    output logic                done_o
);

    genpix_span_state_t r_state, w_state_next;

    logic [DW-1:0]       r_dlc [3];
    logic [DW-1:0]       r_dlr [3];
    logic [WW-1:0]       r_w [3];
    logic [WW-1:0]       r_wrow [3];
    logic [WW-1:0]       r_step [3];
    logic [WW-1:0]       r_off [LANES][3];
    logic [CW-1:0]       r_xc, r_yc, r_xmin, r_ymin, r_xmax, r_ymax;
    logic [AW-1:0]       r_area;

    logic                r_valid_o, r_done_o;
    logic [LANES-1:0]    r_mask_o;
    logic [CW-1:0]       r_x_o, r_y_o;
    logic [AW-1:0]       r_area_o;
    logic [LANES*WW-1:0] r_wout [3];

    logic [DW-1:0]       w_dl_col_in [3];
    logic [DW-1:0]       w_dl_row_in [3];
    logic [WW-1:0]       w_w_row_in [3];
    logic [WW-1:0]       w_dlc_ext [3];
    logic [WW-1:0]       w_dlr_ext [3];
    logic [WW-1:0]       w_lane_w [LANES][3];
    logic [LANES-1:0]    w_inside;
    logic                w_slot_free, w_row_end, w_last_row, w_degenerate;
    logic                w_accept, w_advance, w_done_pulse;

    assign w_dl_col_in[0] = dl_w0_col_i;
    assign w_dl_col_in[1] = dl_w1_col_i;
    assign w_dl_col_in[2] = dl_w2_col_i;
    assign w_dl_row_in[0] = dl_w0_row_i;
    assign w_dl_row_in[1] = dl_w1_row_i;
    assign w_dl_row_in[2] = dl_w2_row_i;
    assign w_w_row_in[0]  = w0_row_i;
    assign w_w_row_in[1]  = w1_row_i;
    assign w_w_row_in[2]  = w2_row_i;

    for (genvar gi = 0; gi < 3; gi++) begin : g_ext
        assign w_dlc_ext[gi] = WW'($signed(r_dlc[gi]));
        assign w_dlr_ext[gi] = WW'($signed(r_dlr[gi]));
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        genpix_lane #(
            .CW (CW),
            .WW (WW),
            .K  (gi)
        ) u_lane (
            .i_base0  (r_w[0]),
            .i_base1  (r_w[1]),
            .i_base2  (r_w[2]),
            .i_off0   (r_off[gi][0]),
            .i_off1   (r_off[gi][1]),
            .i_off2   (r_off[gi][2]),
            .i_x_c    (r_xc),
            .i_x_max  (r_xmax),
            .o_w0     (w_lane_w[gi][0]),
            .o_w1     (w_lane_w[gi][1]),
            .o_w2     (w_lane_w[gi][2]),
            .o_inside (w_inside[gi])
        );
    end

    assign w_slot_free  = !r_valid_o || !busy_i;
    assign w_row_end    = ({1'b0, r_xc} + (CW+1)'(LANES)) > {1'b0, r_xmax};
    assign w_last_row   = ({1'b0, r_yc} + (CW+1)'(1)) > {1'b0, r_ymax};
    assign w_degenerate = (r_xmin > r_xmax) || (r_ymin > r_ymax);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        w_done_pulse = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_i) begin
                    w_accept     = 1'b1;
                    w_state_next = SETUP;
                end
            end
            SETUP: w_state_next = w_degenerate ? FLUSH : SCAN;
            SCAN: begin
                if (w_slot_free) begin
                    w_advance = 1'b1;
                    if (w_row_end && w_last_row) w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                // The final beat leaves on this edge, so done follows it.
                if (w_slot_free) begin
                    w_done_pulse = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int e = 0; e < 3; e++) begin
                r_dlc[e]  <= '0;
                r_dlr[e]  <= '0;
                r_w[e]    <= '0;
                r_wrow[e] <= '0;
                r_step[e] <= '0;
                r_wout[e] <= '0;
                for (int k = 0; k < LANES; k++) r_off[k][e] <= '0;
            end
            r_xc      <= '0;
            r_yc      <= '0;
            r_xmin    <= '0;
            r_ymin    <= '0;
            r_xmax    <= '0;
            r_ymax    <= '0;
            r_area    <= '0;
            r_valid_o <= 1'b0;
            r_done_o  <= 1'b0;
            r_mask_o  <= '0;
            r_x_o     <= '0;
            r_y_o     <= '0;
            r_area_o  <= '0;
        end else begin
            if (w_accept) begin
                for (int e = 0; e < 3; e++) begin
                    r_dlc[e]  <= w_dl_col_in[e];
                    r_dlr[e]  <= w_dl_row_in[e];
                    r_wrow[e] <= w_w_row_in[e];
                end
                r_xmin <= x_min_i;
                r_ymin <= y_min_i;
                r_xmax <= x_max_i;
                r_ymax <= y_max_i;
                r_area <= area_i;
            end

            if (r_state == SETUP) begin
                for (int e = 0; e < 3; e++) begin
                    r_w[e]    <= r_wrow[e];
                    r_step[e] <= WW'(LANES) * w_dlc_ext[e];
                    for (int k = 0; k < LANES; k++) r_off[k][e] <= WW'(k) * w_dlc_ext[e];
                end
                r_xc <= r_xmin;
                r_yc <= r_ymin;
            end

            if (w_advance) begin
                r_x_o     <= r_xc;
                r_y_o     <= r_yc;
                r_mask_o  <= w_inside;
                r_area_o  <= r_area;
                r_valid_o <= (CULL_EMPTY != 0) ? |w_inside : 1'b1;
                for (int e = 0; e < 3; e++)
                    for (int k = 0; k < LANES; k++)
                        r_wout[e][k*WW +: WW] <= w_lane_w[k][e];
                if (w_row_end) begin
                    for (int e = 0; e < 3; e++) begin
                        r_wrow[e] <= r_wrow[e] + w_dlr_ext[e];
                        r_w[e]    <= r_wrow[e] + w_dlr_ext[e];
                    end
                    r_xc <= r_xmin;
                    r_yc <= r_yc + 1'b1;
                end else begin
                    for (int e = 0; e < 3; e++) r_w[e] <= r_w[e] + r_step[e];
                    r_xc <= r_xc + CW'(LANES);
                end
            end else if (w_slot_free) begin
                r_valid_o <= 1'b0;
            end

            r_done_o <= w_done_pulse;
        end
    end

    assign busy_o  = (r_state != IDLE);
    assign x_o     = r_x_o;
    assign y_o     = r_y_o;
    assign w0_o    = r_wout[0];
    assign w1_o    = r_wout[1];
    assign w2_o    = r_wout[2];
    assign mask_o  = r_mask_o;
    assign area_o  = r_area_o;
    assign valid_o = r_valid_o;
    assign done_o  = r_done_o;

endmodule
